// File: rtl/stack_unit.sv
// stack_unit: data stack for the stack CPU. Top-of-stack lives in a register,
// entries 1..depth-1 live in an array. One op per clock:
// PUSH/POP/DUP/SWAP/OVER/REPL/PICK. Reports depth, sticky error and code.
// Ports:
//   i_clock, i_reset_n      clock, async active-low reset
//   i_valid, i_op           op strobe and opcode
//   i_data, i_idx           PUSH/REPL operand, PICK index (0 = top)
//   i_clr_err               clear sticky error
//   o_top, o_next           entries 0 and 1, zero when absent
//   o_pick, o_pick_valid    PICK result and its one-cycle pulse
//   o_depth, o_empty, o_full
//   o_err, o_errcode        sticky error, 01 ovf / 10 udf / 11 bad index
module stack_unit #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16,
  localparam int unsigned SPW = $clog2(DEPTH)
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_valid,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_data,
  input  logic [SPW-1:0]   i_idx,
  input  logic             i_clr_err,
  output logic [WIDTH-1:0] o_top,
  output logic [WIDTH-1:0] o_next,
  output logic [WIDTH-1:0] o_pick,
  output logic             o_pick_valid,
  output logic [SPW:0]     o_depth,
  output logic             o_empty,
  output logic             o_full,
  output logic             o_err,
  output logic [1:0]       o_errcode
);

  localparam int unsigned DW = SPW + 1;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_PUSH = 3'b001;
  localparam logic [2:0] OP_POP  = 3'b010;
  localparam logic [2:0] OP_DUP  = 3'b011;
  localparam logic [2:0] OP_SWAP = 3'b100;
  localparam logic [2:0] OP_OVER = 3'b101;
  localparam logic [2:0] OP_REPL = 3'b110;
  localparam logic [2:0] OP_PICK = 3'b111;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_OVF  = 2'b01;
  localparam logic [1:0] ERR_UDF  = 2'b10;
  localparam logic [1:0] ERR_IDX  = 2'b11;

  // Entry k (k >= 1) is stored at mem[depth-1-k]; addresses wrap modulo DEPTH.
  logic [WIDTH-1:0] mem [DEPTH];

  logic [DW-1:0]    depth_q, depth_d;
  logic [WIDTH-1:0] top_q, top_d;
  logic [WIDTH-1:0] pick_q;
  logic             pick_valid_q;
  logic             err_q, err_d;
  logic [1:0]       code_q, code_d;

  logic             has1_c, has2_c, full_c;
  logic [SPW-1:0]   entry1_addr_c, push_addr_c, pick_addr_c;
  logic [WIDTH-1:0] entry1_c, pick_data_c;
  logic [2:0]       op_c;
  logic             mem_we_c;
  logic [SPW-1:0]   mem_waddr_c;
  logic [WIDTH-1:0] mem_wdata_c;
  logic             pick_ld_c;
  logic [1:0]       err_code_c;

  // Occupancy decode and array addressing
  always_comb begin
    has1_c        = (depth_q != DW'(0));
    has2_c        = (depth_q >= DW'(2));
    full_c        = (depth_q == DW'(DEPTH));
    entry1_addr_c = SPW'(depth_q - DW'(2));
    push_addr_c   = SPW'(depth_q - DW'(1));
    pick_addr_c   = SPW'(depth_q - DW'(1) - DW'(i_idx));
    entry1_c      = mem[entry1_addr_c];
    pick_data_c   = (i_idx == SPW'(0)) ? top_q : mem[pick_addr_c];
    op_c          = i_valid ? i_op : OP_NOP;
  end

  // Op decode: legality, next stack state, array write, error class
  always_comb begin
    depth_d     = depth_q;
    top_d       = top_q;
    mem_we_c    = 1'b0;
    mem_waddr_c = push_addr_c;
    mem_wdata_c = top_q;
    pick_ld_c   = 1'b0;
    err_code_c  = ERR_NONE;
    case (op_c)
      OP_PUSH: begin
        if (full_c) err_code_c = ERR_OVF;
        else begin
          depth_d  = depth_q + DW'(1);
          top_d    = i_data;
          mem_we_c = has1_c;
        end
      end
      OP_POP: begin
        if (!has1_c) err_code_c = ERR_UDF;
        else begin
          depth_d = depth_q - DW'(1);
          top_d   = entry1_c;
        end
      end
      OP_DUP: begin
        if (!has1_c)     err_code_c = ERR_UDF;
        else if (full_c) err_code_c = ERR_OVF;
        else begin
          depth_d  = depth_q + DW'(1);
          mem_we_c = 1'b1;
        end
      end
      OP_SWAP: begin
        if (!has2_c) err_code_c = ERR_UDF;
        else begin
          top_d       = entry1_c;
          mem_we_c    = 1'b1;
          mem_waddr_c = entry1_addr_c;
        end
      end
      OP_OVER: begin
        if (!has2_c)     err_code_c = ERR_UDF;
        else if (full_c) err_code_c = ERR_OVF;
        else begin
          depth_d  = depth_q + DW'(1);
          top_d    = entry1_c;
          mem_we_c = 1'b1;
        end
      end
      OP_REPL: begin
        if (!has1_c) err_code_c = ERR_UDF;
        else         top_d = i_data;
      end
      OP_PICK: begin
        if (DW'(i_idx) >= depth_q) err_code_c = ERR_IDX;
        else                       pick_ld_c  = 1'b1;
      end
      default: ;
    endcase
  end

  // Sticky error: a new error wins over a simultaneous clear
  always_comb begin
    err_d  = err_q;
    code_d = code_q;
    if ((err_code_c != ERR_NONE) && (!err_q || i_clr_err)) begin
      err_d  = 1'b1;
      code_d = err_code_c;
    end else if (i_clr_err) begin
      err_d  = 1'b0;
      code_d = ERR_NONE;
    end
  end

  // Control and status registers
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      depth_q      <= '0;
      top_q        <= '0;
      pick_q       <= '0;
      pick_valid_q <= 1'b0;
      err_q        <= 1'b0;
      code_q       <= ERR_NONE;
    end else begin
      depth_q      <= depth_d;
      top_q        <= top_d;
      pick_valid_q <= pick_ld_c;
      if (pick_ld_c) pick_q <= pick_data_c;
      err_q        <= err_d;
      code_q       <= code_d;
    end
  end

  // Entry array, not reset: masking hides stale contents
  always_ff @(posedge i_clock) begin
    if (mem_we_c) mem[mem_waddr_c] <= mem_wdata_c;
  end

  assign o_top        = has1_c ? top_q : '0;
  assign o_next       = has2_c ? entry1_c : '0;
  assign o_pick       = pick_q;
  assign o_pick_valid = pick_valid_q;
  assign o_depth      = depth_q;
  assign o_empty      = !has1_c;
  assign o_full       = full_c;
  assign o_err        = err_q;
  assign o_errcode    = code_q;

endmodule

// File: tb/tb_stack_unit.sv
// Scoreboard bench for stack_unit (WIDTH=16, DEPTH=4): the stimulus pushes a
// hand-computed expected state per op; a monitor pops and compares it after
// the capturing edge.
module tb_stack_unit;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned SPW   = 2;

  localparam logic [2:0] NOP  = 3'b000;
  localparam logic [2:0] PUSH = 3'b001;
  localparam logic [2:0] POP  = 3'b010;
  localparam logic [2:0] DUP  = 3'b011;
  localparam logic [2:0] SWAP = 3'b100;
  localparam logic [2:0] OVER = 3'b101;
  localparam logic [2:0] REPL = 3'b110;
  localparam logic [2:0] PICK = 3'b111;

  typedef struct {
    int               id;
    logic [WIDTH-1:0] top;
    logic [WIDTH-1:0] next;
    logic [SPW:0]     depth;
    logic             err;
    logic [1:0]       code;
    logic             pv;
    logic [WIDTH-1:0] pick;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             valid = 1'b0;
  logic [2:0]       op = NOP;
  logic [WIDTH-1:0] data = '0;
  logic [SPW-1:0]   idx = '0;
  logic             clr = 1'b0;
  logic [WIDTH-1:0] top, next, pick;
  logic             pick_valid, empty, full, err;
  logic [SPW:0]     depth;
  logic [1:0]       errcode;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   step    = 0;

  stack_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_valid(valid), .i_op(op),
    .i_data(data), .i_idx(idx), .i_clr_err(clr),
    .o_top(top), .o_next(next), .o_pick(pick), .o_pick_valid(pick_valid),
    .o_depth(depth), .o_empty(empty), .o_full(full), .o_err(err),
    .o_errcode(errcode)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int id, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, id, act, exp);
    end
  endtask

  task automatic chk_all(input exp_t e);
    chk("top",   e.id, 32'(top),        32'(e.top));
    chk("next",  e.id, 32'(next),       32'(e.next));
    chk("depth", e.id, 32'(depth),      32'(e.depth));
    chk("empty", e.id, 32'(empty),      32'(e.depth == 3'd0));
    chk("full",  e.id, 32'(full),       32'(e.depth == 3'(DEPTH)));
    chk("err",   e.id, 32'(err),        32'(e.err));
    chk("code",  e.id, 32'(errcode),    32'(e.code));
    chk("pv",    e.id, 32'(pick_valid), 32'(e.pv));
    chk("pick",  e.id, 32'(pick),       32'(e.pick));
  endtask

  // Drive one op on the falling edge and queue its expected post-edge state.
  task automatic drv(input logic v, input logic [2:0] o, input logic [15:0] d,
                     input logic [1:0] ix, input logic c,
                     input logic [15:0] et, input logic [15:0] en,
                     input logic [2:0] ed, input logic ee, input logic [1:0] ec,
                     input logic epv, input logic [15:0] ep);
    exp_t e;
    @(negedge clk);
    valid = v; op = o; data = d; idx = ix; clr = c;
    step++;
    e.id = step; e.top = et; e.next = en; e.depth = ed; e.err = ee;
    e.code = ec; e.pv = epv; e.pick = ep;
    q.push_back(e);
  endtask

  task automatic idle();
    @(negedge clk);
    valid = 1'b0; op = NOP; data = '0; idx = '0; clr = 1'b0;
  endtask

  // Monitor: checks the state produced by each queued op just after its edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) chk_all(q.pop_front());
    end
  end

  initial begin
    exp_t r;
    r.id = 0; r.top = 0; r.next = 0; r.depth = 0; r.err = 0; r.code = 0;
    r.pv = 0; r.pick = 0;
    #3 chk_all(r);
    @(negedge clk) rst_n = 1'b1;

    // fill / drain / overflow / underflow
    drv(1, PUSH, 16'h1111, 0, 0, 16'h1111, 16'h0000, 1, 0, 2'b00, 0, 0);
    drv(1, PUSH, 16'h2222, 0, 0, 16'h2222, 16'h1111, 2, 0, 2'b00, 0, 0);
    drv(1, PUSH, 16'h3333, 0, 0, 16'h3333, 16'h2222, 3, 0, 2'b00, 0, 0);
    drv(1, PUSH, 16'h4444, 0, 0, 16'h4444, 16'h3333, 4, 0, 2'b00, 0, 0);
    drv(1, PUSH, 16'h5555, 0, 0, 16'h4444, 16'h3333, 4, 1, 2'b01, 0, 0);
    drv(1, POP,  16'h0,    0, 0, 16'h3333, 16'h2222, 3, 1, 2'b01, 0, 0);
    drv(1, POP,  16'h0,    0, 0, 16'h2222, 16'h1111, 2, 1, 2'b01, 0, 0);
    drv(1, POP,  16'h0,    0, 0, 16'h1111, 16'h0000, 1, 1, 2'b01, 0, 0);
    drv(1, POP,  16'h0,    0, 0, 16'h0000, 16'h0000, 0, 1, 2'b01, 0, 0);
    drv(1, POP,  16'h0,    0, 0, 16'h0000, 16'h0000, 0, 1, 2'b01, 0, 0);
    drv(0, NOP,  16'h0,    0, 1, 16'h0000, 16'h0000, 0, 0, 2'b00, 0, 0);

    // manipulation
    drv(1, PUSH, 16'h000A, 0, 0, 16'h000A, 16'h0000, 1, 0, 2'b00, 0, 0);
    drv(1, PUSH, 16'h000B, 0, 0, 16'h000B, 16'h000A, 2, 0, 2'b00, 0, 0);
    drv(1, SWAP, 16'h0,    0, 0, 16'h000A, 16'h000B, 2, 0, 2'b00, 0, 0);
    drv(1, OVER, 16'h0,    0, 0, 16'h000B, 16'h000A, 3, 0, 2'b00, 0, 0);
    drv(1, DUP,  16'h0,    0, 0, 16'h000B, 16'h000B, 4, 0, 2'b00, 0, 0);
    drv(1, REPL, 16'h000C, 0, 0, 16'h000C, 16'h000B, 4, 0, 2'b00, 0, 0);
    drv(1, POP,  16'h0,    0, 0, 16'h000B, 16'h000A, 3, 0, 2'b00, 0, 0);
    drv(1, REPL, 16'h000D, 0, 0, 16'h000D, 16'h000A, 3, 0, 2'b00, 0, 0);

    // pick: stack [D, A, B]
    drv(1, PICK, 16'h0, 2, 0, 16'h000D, 16'h000A, 3, 0, 2'b00, 1, 16'h000B);
    drv(1, PICK, 16'h0, 1, 0, 16'h000D, 16'h000A, 3, 0, 2'b00, 1, 16'h000A);
    drv(1, NOP,  16'h0, 0, 0, 16'h000D, 16'h000A, 3, 0, 2'b00, 0, 16'h000A);
    drv(1, PICK, 16'h0, 3, 0, 16'h000D, 16'h000A, 3, 1, 2'b11, 0, 16'h000A);
    drv(1, PICK, 16'h0, 0, 0, 16'h000D, 16'h000A, 3, 1, 2'b11, 1, 16'h000D);
    drv(0, NOP,  16'h0, 0, 1, 16'h000D, 16'h000A, 3, 0, 2'b00, 0, 16'h000D);

    // overflow via DUP, drain, underflow via OVER
    drv(1, PUSH, 16'h000E, 0, 0, 16'h000E, 16'h000D, 4, 0, 2'b00, 0, 16'h000D);
    drv(1, DUP,  16'h0,    0, 0, 16'h000E, 16'h000D, 4, 1, 2'b01, 0, 16'h000D);
    drv(0, NOP,  16'h0,    0, 1, 16'h000E, 16'h000D, 4, 0, 2'b00, 0, 16'h000D);
    drv(1, POP,  16'h0,    0, 0, 16'h000D, 16'h000A, 3, 0, 2'b00, 0, 16'h000D);
    drv(1, POP,  16'h0,    0, 0, 16'h000A, 16'h000B, 2, 0, 2'b00, 0, 16'h000D);
    drv(1, POP,  16'h0,    0, 0, 16'h000B, 16'h0000, 1, 0, 2'b00, 0, 16'h000D);
    drv(1, POP,  16'h0,    0, 0, 16'h0000, 16'h0000, 0, 0, 2'b00, 0, 16'h000D);
    drv(1, PUSH, 16'h0007, 0, 0, 16'h0007, 16'h0000, 1, 0, 2'b00, 0, 16'h000D);
    drv(1, OVER, 16'h0,    0, 0, 16'h0007, 16'h0000, 1, 1, 2'b10, 0, 16'h000D);
    drv(0, NOP,  16'h0,    0, 1, 16'h0007, 16'h0000, 1, 0, 2'b00, 0, 16'h000D);
    drv(1, POP,  16'h0,    0, 0, 16'h0000, 16'h0000, 0, 0, 2'b00, 0, 16'h000D);

    // bad index on empty, then clear with simultaneous new error
    drv(1, PICK, 16'h0,    0, 0, 16'h0000, 16'h0000, 0, 1, 2'b11, 0, 16'h000D);
    drv(1, POP,  16'h0,    0, 1, 16'h0000, 16'h0000, 0, 1, 2'b10, 0, 16'h000D);
    drv(1, DUP,  16'h0,    0, 0, 16'h0000, 16'h0000, 0, 1, 2'b10, 0, 16'h000D);
    drv(0, PUSH, 16'h0009, 0, 0, 16'h0000, 16'h0000, 0, 1, 2'b10, 0, 16'h000D);
    drv(1, PUSH, 16'h0001, 0, 0, 16'h0001, 16'h0000, 1, 1, 2'b10, 0, 16'h000D);
    drv(1, PUSH, 16'h0002, 0, 0, 16'h0002, 16'h0001, 2, 1, 2'b10, 0, 16'h000D);
    drv(1, PUSH, 16'h0003, 0, 0, 16'h0003, 16'h0002, 3, 1, 2'b10, 0, 16'h000D);

    // async reset mid-cycle with depth 3 and error set
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    r.id = 900;
    chk_all(r);
    idle();
    idle();
    rst_n = 1'b1;
    drv(1, PUSH, 16'h0005, 0, 0, 16'h0005, 16'h0000, 1, 0, 2'b00, 0, 16'h0000);
    idle();

    repeat (3) @(posedge clk);
    #2;
    chk("queue_drained", 999, 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
